fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream consumer of the 8-bit synchronous FIFO. It pops one byte at a time when the FIFO is non-empty and serialises it as an 8N1 UART frame on a single output line. It is the transmit stage that drains the FIFO to an off-chip serial link. It is the FIFO's only reader.

Parameters:
DATA_WIDTH, 8, width of FIFO word and UART data field; must match the FIFO.
CLKS_PER_BIT, 16, clk cycles per UART bit; minimum 2.

Ports:
clk  input  1  system clock; rising edge.
rst  input  1  asynchronous, active-low reset.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  DATA_WIDTH  FIFO read data; valid one cycle after the read_enable cycle.
read_enable  output  1  FIFO pop strobe; connects to the FIFO read_enable.
tx  output  1  UART serial line; idles high.
busy  output  1  high from POP until the end of STOP.
tx_done  output  1  one-cycle pulse on the last STOP cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, tx=1, read_enable=0, busy=0, tx_done=0.
  - Shift register and baud counter are cleared.
  - Reset mid-frame aborts the frame immediately; the popped byte is lost and is not re-read.
- All outputs are registered.
- States: IDLE, POP, CAPT, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If fifo_empty=0 at the clock edge, go to POP.
- POP:
  - read_enable=1 for exactly one cycle, then go to CAPT.
- CAPT:
  - Latch fifo_dout into the shift register, then go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - DATA_WIDTH bits, LSB first; each bit is held CLKS_PER_BIT cycles.
  - A bit index counter counts 0..DATA_WIDTH-1.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle, then go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. It is reset on every state entry.
- Frame length is exactly 10*CLKS_PER_BIT cycles of START+DATA+STOP.
- Timing from the first edge where IDLE samples fifo_empty=0:
  - read_enable is high on the next cycle.
  - tx falls 2 cycles later.
- Back-to-back frames: minimum inter-frame idle-high gap on tx is 3 cycles (IDLE, POP, CAPT).
- read_enable is never asserted while fifo_empty=1, because the flag is sampled only in IDLE.
- fifo_empty and fifo_dout changes outside IDLE/CAPT are ignored.
- A write to the FIFO during a frame does not disturb the frame in progress.
- FIFO full condition is not observed; writer back-pressure is the FIFO's responsibility.

Decomposition:
- Shared header fifo_uart_defs holds:
  - state encodings (3-bit localparams S_IDLE..S_STOP);
  - UART idle level, start level and stop level constants.
- One natural sub-module: uart_baud_tick.
  - Counter with synchronous clear input and tick output on count==CLKS_PER_BIT-1.
  - Uses the same clk and rst.
- All other logic stays in fifo_uart_tx.

Test Plan (CLKS_PER_BIT=4, bench instantiates FIFO + fifo_uart_tx):
- Empty FIFO, 200 cycles after reset release -> read_enable never 1, tx constant 1, busy 0.
- Write 0x11 -> one read_enable pulse; tx bits each held 4 cycles are 0,1,0,0,0,1,0,0,0,1; tx_done pulses once; FIFO empty afterwards.
- Write 0x11,0x22,0x33,0x44 consecutively -> exactly 4 read_enable pulses; decoded bytes arrive in order 11,22,33,44; each inter-frame gap is 3 cycles; busy drops only after the 4th stop bit.
- Bytes 0x00 and 0xFF -> data field is all 0 (line low for 36 cycles incl. start) and all 1 respectively; stop bit always 1.
- Assert rst low during DATA bit 3 of 0xA5, release, then write 0x5A -> tx=1 immediately at reset; next frame decodes 0x5A only; no partial 0xA5 completes.
- Write 0x3C while a frame of 0x11 is mid-DATA -> 0x11 frame is unchanged; 0x3C is popped in the cycle after the 0x11 STOP state ends and is transmitted next.

Source files
------------

// File: rtl/fifo_uart_defs_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: state codes,
// line levels and a width helper.
package fifo_uart_defs;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the last count and
// can be restarted synchronously on a state entry.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the synchronous FIFO and sends each one as an 8N1 UART
// frame, LSB first. All outputs come straight from flops.
module fifo_uart_tx
  import fifo_uart_defs::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  read_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic [2:0]            state_dbg
);

  localparam int BAUD_W = idx_w(CLKS_PER_BIT);
  localparam int IDX_W  = idx_w(DATA_WIDTH);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_dn;
  logic [IDX_W-1:0]      bit_idx;
  logic                  bit_last;
  logic                  baud_clr;
  logic                  tick;
  logic [BAUD_W-1:0]     baud_cnt;

  assign state_dbg = state;
  assign shift_dn  = shift_reg >> 1;
  assign bit_last  = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  // The baud counter restarts on every state change so each phase starts at 0.
  assign baud_clr  = (state_nxt != state);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (BAUD_W)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr   (baud_clr),
    .tick  (tick),
    .count (baud_cnt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_POP;
      S_POP:   state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_START;
      S_START: if (tick) state_nxt = S_DATA;
      S_DATA:  if (tick && bit_last) state_nxt = S_STOP;
      S_STOP:  if (tick) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO handshake: fifo_empty=0 acts as valid and is only looked at in IDLE;
  // read_enable is a one-cycle pop and fifo_dout is taken the cycle after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      tx          <= UART_IDLE;
      read_enable <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      shift_reg   <= '0;
      bit_idx     <= '0;
    end else begin
      state       <= state_nxt;
      read_enable <= (state_nxt == S_POP);
      // Raised one count early so the pulse lands on the last STOP cycle.
      tx_done     <= (state == S_STOP) && (baud_cnt == BAUD_W'(CLKS_PER_BIT - 2));
      unique case (state)
        S_IDLE: begin
          tx <= UART_IDLE;
          if (!fifo_empty) busy <= 1'b1;
        end
        S_CAPT: begin
          shift_reg <= fifo_dout;
          bit_idx   <= '0;
          tx        <= UART_START;
        end
        S_START: begin
          if (tick) tx <= shift_reg[0];
        end
        S_DATA: begin
          if (tick) begin
            if (bit_last) begin
              tx <= UART_STOP;
            end else begin
              tx        <= shift_dn[0];
              shift_reg <= shift_dn;
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: a small behavioural FIFO feeds fifo_uart_tx (4 clks/bit) and
// every frame on tx is captured and compared against hand-computed patterns.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty;
  logic       read_enable;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO model ----------------
  logic [7:0] fmem[16];
  int fcnt = 0;
  int frd  = 0;
  int fwr  = 0;

  always @(posedge clk) begin
    if (wr_en) begin
      fmem[fwr] <= wr_data;
      fwr <= (fwr + 1) % 16;
    end
    if (read_enable && fcnt > 0) begin
      fifo_dout <= fmem[frd];
      frd <= (frd + 1) % 16;
    end
    fcnt <= fcnt + (wr_en ? 1 : 0) - ((read_enable && fcnt > 0) ? 1 : 0);
  end

  assign fifo_empty = (fcnt == 0);

  fifo_uart_tx #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .read_enable (read_enable),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done),
    .state_dbg   (state_dbg)
  );

  // ---------------- pulse counters ----------------
  int re_cnt   = 0;
  int done_cnt = 0;
  int re_viol  = 0;

  always begin
    @(posedge clk);
    #2;
    if (read_enable === 1'b1) begin
      re_cnt++;
      if (fcnt == 0) re_viol++;
    end
    if (tx_done === 1'b1) done_cnt++;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Captures one frame sampled on negedges. bits[0] is the start bit.
  // idle = high negedges seen before the start bit; clean = every bit held
  // exactly CPB samples, busy high throughout, tx_done only on the last sample.
  task automatic capture(output logic [9:0] bits, output int idle, output bit clean);
    logic s;
    bits  = '0;
    idle  = 0;
    clean = 1'b1;
    @(negedge clk);
    while (tx !== 1'b0 && idle < 400) begin
      idle++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      check("frame_start_timeout", {31'd0, tx}, 32'd0);
      clean = 1'b0;
      return;
    end
    for (int idx = 0; idx < 10 * CPB; idx++) begin
      if (idx > 0) @(negedge clk);
      s = tx;
      if (idx % CPB == 0) bits[idx / CPB] = s;
      else if (s !== bits[idx / CPB]) clean = 1'b0;
      if (busy !== 1'b1) clean = 1'b0;
      if (tx_done !== (idx == 10 * CPB - 1)) clean = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] din;
    logic [9:0] exp_frame;  // bit 0 = first bit on the line
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [9:0] fb;
    logic [9:0] fbs[4];
    int gi;
    int gis[4];
    bit cl;
    bit cls[4];
    int re0, d0, bad_tx, bad_re, bad_busy, low_seen, waited;
    logic [7:0] got, want;

    vecs[0] = '{din: 8'h11, exp_frame: 10'b1000100010};
    vecs[1] = '{din: 8'h00, exp_frame: 10'b1000000000};
    vecs[2] = '{din: 8'hFF, exp_frame: 10'b1111111110};
    vecs[3] = '{din: 8'hA5, exp_frame: 10'b1101001010};
    vecs[4] = '{din: 8'h5A, exp_frame: 10'b1010110100};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_read_enable", {31'd0, read_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b1;

    // Empty FIFO: nothing happens for 200 cycles
    bad_tx = 0; bad_re = 0; bad_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (read_enable !== 1'b0) bad_re++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("empty_tx_high", bad_tx, 0);
    check("empty_no_pop", bad_re, 0);
    check("empty_not_busy", bad_busy, 0);

    // Pop/start latency after the write lands
    push(8'h11);
    check("lat_idle_re", {31'd0, read_enable}, 32'd0);
    @(negedge clk);
    check("lat_pop_re", {31'd0, read_enable}, 32'd1);
    check("lat_pop_busy", {31'd0, busy}, 32'd1);
    check("lat_pop_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("lat_capt_re", {31'd0, read_enable}, 32'd0);
    check("lat_capt_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("lat_start_tx", {31'd0, tx}, 32'd0);
    waited = 0;
    while (tx_done !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("lat_frame_done", {31'd0, tx_done}, 32'd1);
    @(negedge clk);

    // Table: one byte per frame
    for (int v = 0; v < 5; v++) begin
      re0 = re_cnt;
      d0  = done_cnt;
      push(vecs[v].din);
      capture(fb, gi, cl);
      @(negedge clk);
      check($sformatf("frame_%02h", vecs[v].din), {22'd0, fb}, {22'd0, vecs[v].exp_frame});
      check($sformatf("clean_%02h", vecs[v].din), {31'd0, cl}, 32'd1);
      check($sformatf("pops_%02h", vecs[v].din), re_cnt - re0, 1);
      check($sformatf("done_%02h", vecs[v].din), done_cnt - d0, 1);
      check($sformatf("fifo_empty_%02h", vecs[v].din), {31'd0, fifo_empty}, 32'd1);
    end

    // Back-to-back burst
    re0 = re_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    fork
      begin
        for (int k = 0; k < 4; k++) capture(fbs[k], gis[k], cls[k]);
      end
      begin
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      end
    join
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      got  = fbs[k][8:1];
      want = exp_q.pop_front();
      check($sformatf("burst_byte%0d", k), {24'd0, got}, {24'd0, want});
      check($sformatf("burst_clean%0d", k), {31'd0, cls[k]}, 32'd1);
      check($sformatf("burst_stop%0d", k), {31'd0, fbs[k][9]}, 32'd1);
      if (k > 0) check($sformatf("burst_gap%0d", k), gis[k], 3);
    end
    check("burst_pops", re_cnt - re0, 4);
    check("burst_busy_low", {31'd0, busy}, 32'd0);
    check("burst_fifo_empty", {31'd0, fifo_empty}, 32'd1);

    // Reset during DATA bit 3 of 0xA5
    re0 = re_cnt;
    push(8'hA5);
    waited = 0;
    while (tx !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("abort_start_seen", {31'd0, tx}, 32'd0);
    repeat (4 * CPB + 1) @(negedge clk);
    check("abort_bit3_level", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_tx_high", {31'd0, tx}, 32'd1);
    check("abort_busy_low", {31'd0, busy}, 32'd0);
    check("abort_state_idle", {29'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    d0 = done_cnt;
    low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen++;
    end
    check("abort_no_partial", low_seen, 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_reread", re_cnt - re0, 1);
    push(8'h5A);
    capture(fb, gi, cl);
    check("abort_next_frame", {22'd0, fb}, {22'd0, 10'b1010110100});
    check("abort_next_clean", {31'd0, cl}, 32'd1);

    // Write during a frame in progress
    @(negedge clk);
    re0 = re_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h3C);
    fork
      begin
        capture(fbs[0], gis[0], cls[0]);
        capture(fbs[1], gis[1], cls[1]);
      end
      begin
        push(8'h11);
        repeat (20) @(negedge clk);
        push(8'h3C);
      end
    join
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      got  = fbs[k][8:1];
      want = exp_q.pop_front();
      check($sformatf("midwr_byte%0d", k), {24'd0, got}, {24'd0, want});
      check($sformatf("midwr_clean%0d", k), {31'd0, cls[k]}, 32'd1);
    end
    check("midwr_frame0", {22'd0, fbs[0]}, {22'd0, 10'b1000100010});
    check("midwr_gap", gis[1], 3);
    check("midwr_pops", re_cnt - re0, 2);

    check("pop_while_empty", re_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
